// File: rtl/uart_defines.sv
// Shared UART definitions: FSM state encoding, oversample factor and frame widths.
// Used by the receiver and intended for the future transmitter.
package uart_defines;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } rx_state_e;

  localparam int OSR     = 16;
  localparam int CENTRE  = 7;
  localparam int DATA_W  = 8;
  localparam int PHASE_W = $clog2(OSR);
  localparam int BIT_W   = $clog2(DATA_W);

  // Clocks per oversample tick, never below one.
  function automatic int os_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * OSR);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with registered head; extra pointer bit separates full from empty.
// A full FIFO still accepts a push when a pop happens in the same cycle.
module uart_rx_fifo
  import uart_defines::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       rd_n;
  logic              do_push;
  logic              do_pop;
  logic              bypass;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_n    = rd_ptr + {{AW{1'b0}}, do_pop};

  // New byte becomes the head when it lands in the slot about to be read.
  assign bypass = do_push && (wr_ptr[AW-1:0] == rd_n[AW-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_n;
      head   <= bypass ? din : mem[rd_n[AW-1:0]];
    end
  end

endmodule

// File: rtl/uart_rx_host.sv
// Host-side UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined)
// feeding a valid/ready FIFO; sticky overrun, one-cycle frame/parity pulses.
module uart_rx_host
  import uart_defines::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rx_in,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  input  logic              clr_err_in
);

  localparam int DIV = os_div(CLK_FREQ, BAUD_RATE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  rx_state_e state;
  rx_state_e state_n;

  logic              sync1;
  logic              rxs;
  logic              rxs_d;
  logic              fall;
  logic [CW-1:0]     div_cnt;
  logic              tick;
  logic [PHASE_W-1:0] phase;
  logic              centre;
  logic [DATA_W-1:0] shift;
  logic [BIT_W-1:0]  bit_cnt;
  logic              phase_clr;
  logic              shift_en;
  logic              push;
  logic              ferr_set;
  logic              pop;
  logic              drop;
  logic              full;
  logic              empty;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  assign fall = rxs_d && !rxs;

  assign tick   = (div_cnt == CW'(DIV - 1));
  assign centre = tick && (phase == PHASE_W'(CENTRE));

  always_ff @(posedge clk_in) begin
    if (rst_in || phase_clr) begin
      div_cnt <= '0;
      phase   <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      phase   <= phase + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic par_en;
  logic perr_set;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    phase_clr = 1'b0;
    shift_en  = 1'b0;
    push      = 1'b0;
    ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en    = 1'b0;
    perr_set  = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (fall) begin
          state_n   = S_START;
          phase_clr = 1'b1;
        end
      end
      S_START: begin
        if (centre) begin
          state_n = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (centre) begin
          shift_en = 1'b1;
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (centre) begin
          par_en  = 1'b1;
          state_n = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Leave at the stop-bit centre so a back-to-back start edge is seen.
        if (centre) begin
          state_n = S_IDLE;
          if (!rxs) begin
            ferr_set = 1'b1;
            state_n  = S_WAIT_IDLE;
          end
`ifdef UART_RX_PARITY_EN
          else if (par_bad) begin
            perr_set = 1'b1;
          end
`endif
          else begin
            push = 1'b1;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rxs) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else begin
      if (phase_clr) begin
        bit_cnt <= '0;
      end
      if (shift_en) begin
        shift   <= {rxs, shift[DATA_W-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (phase_clr) begin
        par_bad <= 1'b0;
      end
      if (par_en) begin
        par_bad <= rxs ^ (^shift);
      end
      parity_err <= perr_set;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign pop  = dout_valid && dout_ready;
  assign drop = push && full && !pop;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_err_in) begin
        overrun <= 1'b0;
      end
    end
  end

  uart_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (push),
    .din   (shift),
    .pop   (pop),
    .head  (dout),
    .full  (full),
    .empty (empty)
  );

  assign dout_valid = !empty;

endmodule

// File: tb/tb_uart_rx_host.sv
// Bench for uart_rx_host at 16 clocks per bit: table vectors, corner
// sequences and a random frame stream against a queue-based reference.
module tb_uart_rx_host;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       clr_err = 1'b0;

  logic       ready_cmd = 1'b0;
  logic       rand_mode = 1'b0;

  int checks = 0;
  int failures = 0;
  int n_ferr = 0;
  int n_perr = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  uart_rx_host #(
    .CLK_FREQ  (1600000),
    .BAUD_RATE (100000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .rx_in     (rx),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .clr_err_in(clr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    dout_ready = rand_mode ? 1'($urandom % 2) : ready_cmd;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (dout_valid && dout_ready) got.push_back(dout);
      if (frame_err) n_ferr++;
      if (parity_err) n_perr++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic par_flip);
    rx = 1'b0;
    cyc(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      cyc(16);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    cyc(16);
`else
    if (par_flip) rx = 1'b1;
`endif
    rx = stop;
    cyc(16);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       bad_par;
    logic       exp_byte;
    int         exp_ferr;
    int         exp_perr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int gb, fb, pb, ef;

    tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 0, 0};
    tbl[1] = '{8'h00, 1'b1, 1'b0, 1'b1, 0, 0};
    tbl[2] = '{8'hFF, 1'b1, 1'b0, 1'b1, 0, 0};
    tbl[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1, 0};
    tbl[4] = '{8'h81, 1'b1, 1'b0, 1'b1, 0, 0};
`ifdef UART_RX_PARITY_EN
    tbl[5] = '{8'h07, 1'b1, 1'b1, 1'b0, 0, 1};
`else
    tbl[5] = '{8'h07, 1'b1, 1'b1, 1'b1, 0, 0};
`endif

    cyc(3);
    rst = 1'b0;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_overrun", overrun, 0);
    cyc(5);

    // Table vectors, consumer always ready
    ready_cmd = 1'b1;
    for (int v = 0; v < 6; v++) begin
      gb = got.size();
      fb = n_ferr;
      pb = n_perr;
      send_frame(tbl[v].data, tbl[v].stop, tbl[v].bad_par);
      cyc(40);
      chk($sformatf("vec%0d_nbytes", v), got.size() - gb,
          int'(tbl[v].exp_byte));
      if (tbl[v].exp_byte && got.size() > gb)
        chk($sformatf("vec%0d_data", v), got[gb], tbl[v].data);
      chk($sformatf("vec%0d_ferr", v), n_ferr - fb, tbl[v].exp_ferr);
      chk($sformatf("vec%0d_perr", v), n_perr - pb, tbl[v].exp_perr);
    end

    // Back-to-back frames with no idle gap
    gb = got.size();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    cyc(40);
    chk("b2b_count", got.size() - gb, 3);
    if (got.size() - gb == 3) begin
      chk("b2b_0", got[gb], 8'h00);
      chk("b2b_1", got[gb+1], 8'hFF);
      chk("b2b_2", got[gb+2], 8'h55);
    end

    // Start-bit glitch, then a normal frame proves recovery
    gb = got.size();
    fb = n_ferr;
    rx = 1'b0;
    cyc(4);
    rx = 1'b1;
    cyc(48);
    chk("glitch_bytes", got.size() - gb, 0);
    chk("glitch_ferr", n_ferr - fb, 0);
    send_frame(8'h96, 1'b1, 1'b0);
    cyc(40);
    chk("glitch_recover_n", got.size() - gb, 1);
    if (got.size() > gb) chk("glitch_recover_d", got[gb], 8'h96);

    // Framing error followed by a 40-bit break
    gb = got.size();
    fb = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    cyc(40 * 16);
    rx = 1'b1;
    cyc(48);
    chk("break_ferr", n_ferr - fb, 1);
    chk("break_bytes", got.size() - gb, 0);
    send_frame(8'h12, 1'b1, 1'b0);
    cyc(40);
    chk("break_next_n", got.size() - gb, 1);
    if (got.size() > gb) chk("break_next_d", got[gb], 8'h12);

    // Overrun: five bytes into a four-deep FIFO with no consumer
    ready_cmd = 1'b0;
    cyc(3);
    gb = got.size();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    cyc(40);
    chk("ovr_set", overrun, 1);
    chk("ovr_valid", dout_valid, 1);
    chk("ovr_head", dout, 8'h01);
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    cyc(1);
    chk("ovr_clr", overrun, 0);
    ready_cmd = 1'b1;
    cyc(20);
    chk("ovr_count", got.size() - gb, 4);
    if (got.size() - gb == 4)
      for (int i = 0; i < 4; i++)
        chk($sformatf("ovr_b%0d", i), got[gb+i], i + 1);
    chk("ovr_drained", dout_valid, 0);

    // Reset mid-frame with a stale byte queued
    ready_cmd = 1'b0;
    cyc(3);
    gb = got.size();
    send_frame(8'h5A, 1'b1, 1'b0);
    cyc(30);
    chk("rstf_queued", dout_valid, 1);
    rx = 1'b0;
    cyc(16);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      cyc(16);
    end
    rx = 1'b1;
    cyc(8);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    chk("rstf_valid", dout_valid, 0);
    chk("rstf_dout", dout, 0);
    ready_cmd = 1'b1;
    cyc(300);
    chk("rstf_nobyte", got.size() - gb, 0);
    chk("rstf_valid2", dout_valid, 0);

    // Random frames, random consumer stalls, occasional bad stop bits
    rand_mode = 1'b1;
    exp_q.delete();
    gb = got.size();
    fb = n_ferr;
    ef = 0;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic bad;
      d = 8'($urandom);
      bad = ($urandom % 6) == 0;
      send_frame(d, !bad, 1'b0);
      if (bad) begin
        ef++;
        cyc(32);
      end else begin
        exp_q.push_back(d);
      end
      cyc($urandom % 40);
    end
    cyc(80);
    chk("rand_count", got.size() - gb, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (gb + i < got.size())
        chk($sformatf("rand_b%0d", i), got[gb+i], exp_q[i]);
    chk("rand_ferr", n_ferr - fb, ef);
    chk("rand_overrun", overrun, 0);
    rand_mode = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
